// File: rtl/reg_file_pkg.sv
// Shared defaults and index/data typedefs for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_NUM_WR = 2;

  typedef logic [RF_ADDR_W-1:0] rf_idx_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// ID/WB bus of the register file: master = pipeline stages, slave = register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned NUM_WR = RF_NUM_WR
) ();

  logic [NUM_WR-1:0]        WB_wen;
  logic [NUM_WR*ADDR_W-1:0] WB_rd;
  logic [NUM_WR*DATA_W-1:0] WB_wdata;
  logic [NUM_RD*ADDR_W-1:0] ID_ra;
  logic [NUM_RD*DATA_W-1:0] ID_rdata;
  logic                     ID_issue_en;
  logic [ADDR_W-1:0]        ID_issue_rd;
  logic [NUM_RD-1:0]        ID_pending;

  modport master (
    output WB_wen, WB_rd, WB_wdata, ID_ra, ID_issue_en, ID_issue_rd,
    input  ID_rdata, ID_pending
  );

  modport slave (
    input  WB_wen, WB_rd, WB_wdata, ID_ra, ID_issue_en, ID_issue_rd,
    output ID_rdata, ID_pending
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register pending flags: set on issue, cleared by writeback, issue wins on a tie.
// Optional same-cycle forwarding of the clear when REGFILE_BYPASS_EN is defined.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned NUM_WR = RF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_issue_en,
  input  logic [ADDR_W-1:0]        i_issue_rd,
  input  logic [NUM_WR-1:0]        i_wen,
  input  logic [NUM_WR*ADDR_W-1:0] i_wrd,
  input  logic [NUM_RD*ADDR_W-1:0] i_ra,
  output logic [NUM_RD-1:0]        o_pending_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_pending_nxt;
  logic [ADDR_W-1:0] w_idx;

  // Writeback clears, issue sets; index 0 can never become pending
  always_comb begin
    w_clr = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (i_wen[p]) w_clr[i_wrd[p*ADDR_W +: ADDR_W]] = 1'b1;
    end
    w_pending_nxt = r_pending & ~w_clr;
    if (i_issue_en) w_pending_nxt[i_issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  always_comb begin
    o_pending_c = '0;
    w_idx       = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_idx          = i_ra[r*ADDR_W +: ADDR_W];
      o_pending_c[r] = r_pending[w_idx];
`ifdef REGFILE_BYPASS_EN
      if (w_clr[w_idx] && !(i_issue_en && (i_issue_rd == w_idx))) o_pending_c[r] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file (NUM_RD comb reads, NUM_WR writes, reg 0 hardwired to zero) with pending scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle writeback data to the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned NUM_WR = RF_NUM_WR
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        r_regs [DEPTH];
  logic [NUM_RD*DATA_W-1:0] w_rdata;
  logic [NUM_RD-1:0]        w_pending;
  logic [ADDR_W-1:0]        w_ra;

  // Ports applied in ascending order so the highest-index port wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (bus.WB_wen[p] && (bus.WB_rd[p*ADDR_W +: ADDR_W] != '0)) begin
          r_regs[bus.WB_rd[p*ADDR_W +: ADDR_W]] <= bus.WB_wdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    w_ra    = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_ra = bus.ID_ra[r*ADDR_W +: ADDR_W];
      if (w_ra != '0) w_rdata[r*DATA_W +: DATA_W] = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (bus.WB_wen[p] && (w_ra != '0) && (bus.WB_rd[p*ADDR_W +: ADDR_W] == w_ra)) begin
          w_rdata[r*DATA_W +: DATA_W] = bus.WB_wdata[p*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  reg_file_scoreboard #(
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue_en (bus.ID_issue_en),
    .i_issue_rd (bus.ID_issue_rd),
    .i_wen      (bus.WB_wen),
    .i_wrd      (bus.WB_rd),
    .i_ra       (bus.ID_ra),
    .o_pending_c(w_pending)
  );

  assign bus.ID_rdata   = w_rdata;
  assign bus.ID_pending = w_pending;

endmodule
